// File: rtl/decode_pkg.sv
// Shared decode definitions for the multi-issue decode queue.
// Holds the opcode and func codes, the ALU control encoding, the packed
// control word ctrl_t and its width CTRL_W.
// Optional macro MULDIV_DEC_EN adds muldiv/hiloread below userd2 (CTRL_W 18 -> 20).
package decode_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
`ifdef MULDIV_DEC_EN
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
`endif

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SRA = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_e;

  // Control word, MSB first
  typedef struct packed {
    logic illegal;
    logic memtoreg;
    logic memwrite;
    logic bitshift;
    logic alusrc;
    logic regdst;
    logic regwrite;
    logic jump;
    logic jumpreg;
    logic jumplink;
    alu_e alucontrol;
    logic branchbeq;
    logic branchneq;
    logic userd1;
    logic userd2;
`ifdef MULDIV_DEC_EN
    logic muldiv;
    logic hiloread;
`endif
    logic reserved;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/slot_decoder.sv
// Combinational decode of one MIPS instruction into a ctrl_t control word.
// Ports: valid_i (slot valid), instr_i (raw instruction), ctrl_o (control word).
// An invalid slot yields all zeros; an unknown opcode/func yields only illegal.
// Macro MULDIV_DEC_EN enables mult/div/mfhi/mflo decode.
module slot_decoder
  import decode_pkg::*;
(
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op            = instr_i[31:26];
  assign fn            = instr_i[5:0];
  assign unused_fields = ^instr_i[25:6];

  // Decode; userd1/userd2 flag reads of rs/rt
  always_comb begin
    ctrl_t c;
    logic  bad;
    c   = '0;
    bad = 1'b0;
    if (valid_i) begin
      case (op)
        OP_RTYPE: begin
          c.regdst   = 1'b1;
          c.regwrite = 1'b1;
          c.userd1   = 1'b1;
          c.userd2   = 1'b1;
          case (fn)
            FN_SLL: begin c.bitshift = 1'b1; c.userd1 = 1'b0; c.alucontrol = ALU_SLL; end
            FN_SRL: begin c.bitshift = 1'b1; c.userd1 = 1'b0; c.alucontrol = ALU_SRL; end
            FN_SRA: begin c.bitshift = 1'b1; c.userd1 = 1'b0; c.alucontrol = ALU_SRA; end
            FN_JR: begin
              c.regdst   = 1'b0;
              c.regwrite = 1'b0;
              c.userd2   = 1'b0;
              c.jumpreg  = 1'b1;
            end
            FN_ADD, FN_ADDU: c.alucontrol = ALU_ADD;
            FN_SUB, FN_SUBU: c.alucontrol = ALU_SUB;
            FN_AND:          c.alucontrol = ALU_AND;
            FN_OR:           c.alucontrol = ALU_OR;
            FN_SLT:          c.alucontrol = ALU_SLT;
`ifdef MULDIV_DEC_EN
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              c.regdst   = 1'b0;
              c.regwrite = 1'b0;
              c.muldiv   = 1'b1;
            end
            FN_MFHI, FN_MFLO: begin
              c.userd1   = 1'b0;
              c.userd2   = 1'b0;
              c.hiloread = 1'b1;
            end
`endif
            default: bad = 1'b1;
          endcase
        end
        OP_LW: begin
          c.memtoreg = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
          c.alucontrol = ALU_ADD; c.userd1 = 1'b1;
        end
        OP_SW: begin
          c.memwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_ADD;
          c.userd1 = 1'b1; c.userd2 = 1'b1;
        end
        OP_BEQ: begin
          c.branchbeq = 1'b1; c.alucontrol = ALU_SUB; c.userd1 = 1'b1; c.userd2 = 1'b1;
        end
        OP_BNE: begin
          c.branchneq = 1'b1; c.alucontrol = ALU_SUB; c.userd1 = 1'b1; c.userd2 = 1'b1;
        end
        OP_ADDI, OP_ADDIU: begin
          c.alusrc = 1'b1; c.regwrite = 1'b1; c.alucontrol = ALU_ADD; c.userd1 = 1'b1;
        end
        OP_SLTI: begin
          c.alusrc = 1'b1; c.regwrite = 1'b1; c.alucontrol = ALU_SLT; c.userd1 = 1'b1;
        end
        OP_ANDI: begin
          c.alusrc = 1'b1; c.regwrite = 1'b1; c.alucontrol = ALU_AND; c.userd1 = 1'b1;
        end
        OP_ORI: begin
          c.alusrc = 1'b1; c.regwrite = 1'b1; c.alucontrol = ALU_OR; c.userd1 = 1'b1;
        end
        OP_J:   c.jump = 1'b1;
        OP_JAL: begin c.jump = 1'b1; c.jumplink = 1'b1; c.regwrite = 1'b1; end
        default: bad = 1'b1;
      endcase
    end
    // jump covers both direct jumps and jr
    c.jump = c.jump | c.jumpreg;
    if (bad) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    ctrl_o = c;
  end

endmodule

// File: rtl/multi_issue_decode_queue.sv
// In-order queue of decoded instruction bundles for the superscalar front end.
// Ports: clk, reset (async, active-high), flush (sync clear);
//   in_valid/in_ready/in_slot_valid/in_instr  - bundle enqueue, decoded on entry;
//   out_valid/out_ready/out_slot_valid/out_instr/out_ctrl - head bundle to issue;
//   count - occupied entries.
// Macro MULDIV_DEC_EN widens out_ctrl slots to 20 bits with mult/div decode.
module multi_issue_decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_slot_valid,
  input  logic [WIDTH*IW-1:0]           in_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_slot_valid,
  output logic [WIDTH*IW-1:0]           out_instr,
  output logic [WIDTH*CTRL_W-1:0]       out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0]        sv_q   [DEPTH];
  logic [WIDTH*IW-1:0]     instr_q[DEPTH];
  logic [WIDTH*CTRL_W-1:0] ctrl_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH*CTRL_W-1:0] dec_ctrl;
  logic push, pop;

  // One decoder per slot
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    slot_decoder u_dec (
      .valid_i (in_slot_valid[i]),
      .instr_i (in_instr[i*IW +: 32]),
      .ctrl_o  (dec_ctrl[i*CTRL_W +: CTRL_W])
    );
  end

  assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy next-state; flush wins over push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only observable through a valid head
  always_ff @(posedge clk) begin
    if (push) begin
      sv_q[wr_ptr_q]    <= in_slot_valid;
      instr_q[wr_ptr_q] <= in_instr;
      ctrl_q[wr_ptr_q]  <= dec_ctrl;
    end
  end

  assign out_slot_valid = out_valid ? sv_q[rd_ptr_q]    : '0;
  assign out_instr      = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_ctrl       = out_valid ? ctrl_q[rd_ptr_q]  : '0;
  assign count          = count_q;

endmodule

// File: tb/tb_multi_issue_decode_queue.sv
// Scoreboard bench for multi_issue_decode_queue (WIDTH=2, DEPTH=4).
module tb_multi_issue_decode_queue;
  import decode_pkg::*;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam int unsigned BW    = WIDTH*CTRL_W;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0]    in_slot_valid, out_slot_valid;
  logic [WIDTH*IW-1:0] in_instr, out_instr;
  logic [BW-1:0]       out_ctrl, exp_ctrl;
  logic [CW-1:0]       count;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [WIDTH-1:0]    sv;
    logic [WIDTH*IW-1:0] instr;
    logic [BW-1:0]       ctrl;
  } exp_t;
  exp_t sb[$];

  multi_issue_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_slot_valid(out_slot_valid), .out_instr(out_instr),
    .out_ctrl(out_ctrl), .count(count)
  );

  always #5 clk = ~clk;

  // Instructions and hand-decoded 18-bit control words
  localparam logic [31:0] I_LW   = 32'h8C410004;  localparam logic [17:0] C_LW   = 18'h12844;
  localparam logic [31:0] I_ADD  = 32'h00221820;  localparam logic [17:0] C_ADD  = 18'h01846;
  localparam logic [31:0] I_ORI  = 32'h34220005;  localparam logic [17:0] C_ORI  = 18'h02824;
  localparam logic [31:0] I_SW   = 32'hAC410008;  localparam logic [17:0] C_SW   = 18'h0A046;
  localparam logic [31:0] I_BEQ  = 32'h10220003;  localparam logic [17:0] C_BEQ  = 18'h000D6;
  localparam logic [31:0] I_J    = 32'h08000010;  localparam logic [17:0] C_J    = 18'h00400;
  localparam logic [31:0] I_SLL  = 32'h00021080;  localparam logic [17:0] C_SLL  = 18'h05862;
  localparam logic [31:0] I_JR   = 32'h03E00008;  localparam logic [17:0] C_JR   = 18'h00604;
  localparam logic [31:0] I_ILL  = 32'hFC000000;  localparam logic [17:0] C_ILL  = 18'h20000;
  localparam logic [31:0] I_MULT = 32'h00000018;

  // Map an 18-bit word into the build's layout (two extra zero bits above reserved)
  function automatic logic [CTRL_W-1:0] enc(input logic [17:0] base);
`ifdef MULDIV_DEC_EN
    return {base[17:1], 3'b000};
`else
    return base;
`endif
  endfunction

  function automatic logic [CTRL_W-1:0] mult_word();
`ifdef MULDIV_DEC_EN
    return CTRL_W'(20'h0001C);
`else
    return enc(C_ILL);
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] sv, input logic [31:0] i1,
                      input logic [31:0] i0, input logic [17:0] c1, input logic [17:0] c0,
                      input logic ordy, input logic fl);
    in_valid      = v;
    in_slot_valid = sv;
    in_instr      = {i1, i0};
    exp_ctrl      = {(sv[1] ? enc(c1) : CTRL_W'(0)), (sv[0] ? enc(c0) : CTRL_W'(0))};
    out_ready     = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 32'h0, 32'h0, 18'h0, 18'h0, ordy, 1'b0);
  endtask

  // Track accepted bundles and pops at the edge using pre-edge handshake values
  always @(posedge clk or posedge reset) begin
    if (reset || flush) sb.delete();
    else begin
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) begin
        exp_t e;
        e.sv = in_slot_valid; e.instr = in_instr; e.ctrl = exp_ctrl;
        sb.push_back(e);
      end
    end
  end

  // Compare the head against the scoreboard away from the active edge
  always @(negedge clk) begin
    check("count", 128'(count), 128'(sb.size()));
    check("out_valid", 128'(out_valid), 128'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("head_slot_valid", 128'(out_slot_valid), 128'(sb[0].sv));
      check("head_instr", 128'(out_instr), 128'(sb[0].instr));
      check("head_ctrl", 128'(out_ctrl), 128'(sb[0].ctrl));
    end else begin
      check("empty_outputs", 128'({out_slot_valid, out_instr, out_ctrl}), 128'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ti [6];
    logic [17:0] tc [6];
    ti = '{I_ORI, I_SW, I_BEQ, I_J, I_SLL, I_JR};
    tc = '{C_ORI, C_SW, C_BEQ, C_J, C_SLL, C_JR};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_slot_valid = '0; in_instr = '0; exp_ctrl = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    idle(1'b0, 2);
    check("idle_in_ready", 128'(in_ready), 128'(1));
    check("idle_count", 128'(count), 128'(0));
    check("idle_ctrl", 128'(out_ctrl), 128'(0));

    // lw + add, one-cycle visibility, then pop
    step(1'b1, 2'b11, I_ADD, I_LW, C_ADD, C_LW, 1'b0, 1'b0);
    check("lwadd_count1", 128'(count), 128'(1));
    check("lw_ctrl", 128'(out_ctrl[CTRL_W-1:0]), 128'(enc(C_LW)));
    check("add_ctrl", 128'(out_ctrl[BW-1:CTRL_W]), 128'(enc(C_ADD)));
    idle(1'b1, 1);
    check("lwadd_count0", 128'(count), 128'(0));

    // Fill to DEPTH, then try a fifth bundle
    for (int k = 0; k < 4; k++)
      step(1'b1, 2'b11, ti[(k+1)%6], ti[k], tc[(k+1)%6], tc[k], 1'b0, 1'b0);
    check("full_count", 128'(count), 128'(DEPTH));
    check("full_in_ready", 128'(in_ready), 128'(0));
    step(1'b1, 2'b11, I_LW, I_LW, C_LW, C_LW, 1'b0, 1'b0);
    check("fifth_rejected", 128'(count), 128'(DEPTH));

    // Streaming push/pop across pointer wrap
    for (int k = 0; k < 8; k++)
      step(1'b1, 2'b11, ti[(k+3)%6], ti[(k+2)%6], tc[(k+3)%6], tc[(k+2)%6], 1'b1, 1'b0);
    idle(1'b1, 5);
    check("drain_count", 128'(count), 128'(0));

    // Illegal in slot 0, slot 1 invalid
    step(1'b1, 2'b01, I_ADD, I_ILL, C_ADD, C_ILL, 1'b0, 1'b0);
    check("ill_slot_valid", 128'(out_slot_valid), 128'(2'b01));
    check("ill_slot0", 128'(out_ctrl[CTRL_W-1:0]), 128'(enc(C_ILL)));
    check("ill_slot1", 128'(out_ctrl[BW-1:CTRL_W]), 128'(0));
    idle(1'b1, 1);

    // jr and mult
    in_valid = 1'b1; in_slot_valid = 2'b11; in_instr = {I_MULT, I_JR};
    exp_ctrl = {mult_word(), enc(C_JR)}; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    check("jr_ctrl", 128'(out_ctrl[CTRL_W-1:0]), 128'(enc(C_JR)));
    check("mult_ctrl", 128'(out_ctrl[BW-1:CTRL_W]), 128'(mult_word()));
    idle(1'b1, 1);

    // Flush with 3 entries and a concurrent push
    for (int k = 0; k < 3; k++)
      step(1'b1, 2'b11, ti[k], ti[k+1], tc[k], tc[k+1], 1'b0, 1'b0);
    check("preflush_count", 128'(count), 128'(3));
    step(1'b1, 2'b11, I_LW, I_ADD, C_LW, C_ADD, 1'b1, 1'b1);
    check("flush_count", 128'(count), 128'(0));
    check("flush_out_valid", 128'(out_valid), 128'(0));
    step(1'b1, 2'b10, I_SW, I_ORI, C_SW, C_ORI, 1'b0, 1'b0);
    idle(1'b1, 1);

    // Asynchronous reset mid-burst
    step(1'b1, 2'b11, I_BEQ, I_J, C_BEQ, C_J, 1'b0, 1'b0);
    step(1'b1, 2'b11, I_SLL, I_LW, C_SLL, C_LW, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_outputs", 128'({out_slot_valid, out_instr, out_ctrl}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    idle(1'b0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_issue_decode_queue.md
Name: multi_issue_decode_queue

Overview:
- Parametrised successor to the single-lane control decoder for the superscalar front end.
- Accepts a bundle of up to WIDTH fetched MIPS instructions per cycle with valid/ready handshake.
- Decodes each slot into a packed control word at enqueue, buffers up to DEPTH bundles in order, and presents the oldest bundle to issue.
- Adds buffering, flush, per-slot illegal-op detection and backpressure, none of which the single-lane decoder had.

Parameters:
- WIDTH, 2, instruction slots per bundle (1..4).
- DEPTH, 4, bundle entries in the queue (power of 2, at least 2).
- IW, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous queue clear (branch mispredict or exception).
- in_valid  in  1  input bundle present.
- in_ready  out  1  queue can accept a bundle.
- in_slot_valid  in  WIDTH  per-slot valid; slot 0 is the oldest instruction.
- in_instr  in  WIDTH*IW  slot i occupies bits [i*IW +: IW].
- out_valid  out  1  head bundle present.
- out_ready  in  1  issue consumes the head bundle.
- out_slot_valid  out  WIDTH  stored per-slot valid.
- out_instr  out  WIDTH*IW  raw instructions, passed through for register and immediate fields.
- out_ctrl  out  WIDTH*CTRL_W  decoded control word per slot.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Control word, MSB to LSB (CTRL_W = 18): illegal, memtoreg, memwrite, bitshift, alusrc, regdst, regwrite, jump, jumpreg, jumplink, alucontrol[2:0], branchbeq, branchneq, userd1, userd2, reserved = 0.
- alucontrol encoding: and = 000, or = 001, add = 010, sll = 011, srl = 100, sra = 101, sub = 110, slt = 111.
- Opcodes decoded:
  - R-type 0x00 with func: sll 0x00, srl 0x02, sra 0x03, jr 0x08, add/addu 0x20/0x21, sub/subu 0x22/0x23, and 0x24, or 0x25, slt 0x2A.
  - I/J-type: lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi/addiu 0x08/0x09, slti 0x0A, andi 0x0C, ori 0x0D, j 0x02, jal 0x03.
  - jump = jump-opcode OR jumpreg.
- Any other opcode, or any other func under op 0, sets illegal = 1 and forces all other bits to 0.
- A slot with in_slot_valid = 0 stores an all-zero control word, never illegal.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. It is independent of out_ready, so there is no push-when-full even with a simultaneous pop.
- Latency: a bundle pushed at edge t is visible on the outputs after edge t. There is no combinational input-to-output path.
- Outputs come from the head entry. out_valid = (count != 0).
- Pop and push in the same cycle: count is unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally.
- flush: at the next edge, count, read pointer and write pointer all go to 0. Any concurrent push or pop is ignored. Flush has priority over everything except reset.
- Reset, including mid-operation: count = 0, pointers = 0, out_valid = 0, out_ctrl = 0, out_slot_valid = 0, out_instr = 0.
- When the queue is empty, all head outputs are driven 0.

Optional Feature:
- Macro MULDIV_DEC_EN.
- When defined: CTRL_W = 20 and two bits are added below userd2: muldiv and hiloread.
  - mult 0x18, multu 0x19, div 0x1A and divu 0x1B set muldiv = 1 and regwrite = 0.
  - mfhi 0x10 and mflo 0x12 set hiloread = 1 and regwrite = 1.
- When undefined: those funcs decode as illegal and CTRL_W = 18.

Decomposition:
- Package decode_pkg holds:
  - opcode and func localparams;
  - alucontrol enum;
  - ctrl_t packed struct, with the macro-dependent fields;
  - CTRL_W.
- Sub-module slot_decoder: combinational decode of one IW-bit instruction plus its slot valid into ctrl_t, instantiated WIDTH times via generate.
- The queue storage and pointer logic live in the top module.

Test Plan:
- Reset then idle: out_valid = 0, count = 0, in_ready = 1, out_ctrl = 0.
- WIDTH = 2: push {0x8C410004 (lw), 0x00221820 (add)}, then out_ready = 1 one cycle later. Required:
  - slot 0: memtoreg = 1, alusrc = 1, regwrite = 1, alucontrol = 010;
  - slot 1: regdst = 1, regwrite = 1, alucontrol = 010;
  - count goes 1 then 0.
- Fill: push 4 bundles with out_ready = 0. Required: count = 4, in_ready = 0, fifth bundle not accepted. Then pop and push together: count stays 4, order preserved across pointer wrap.
- Illegal: push slot 0 = 0xFC000000, slot 1 invalid. Required: slot 0 illegal = 1 with all other bits 0; slot 1 word = 0 and out_slot_valid = 01.
- Flush with 3 entries plus a concurrent push: next cycle count = 0 and out_valid = 0. Assert reset asynchronously mid-burst: outputs 0 immediately.
- jr 0x03E00008: jump = 1, jumpreg = 1. Also decode 0x00000018 (mult): with MULDIV_DEC_EN, muldiv = 1; without it, illegal = 1.
